// File: rtl/fifo16_pkg.sv
// Shared widths, RAM write payload and pointer helper for the 16-entry FIFO controller.
package fifo16_pkg;

    localparam int unsigned DEPTH  = 16;
    localparam int unsigned PTR_W  = 4;
    localparam int unsigned CNT_W  = 5;
    localparam int unsigned DATA_W = 32;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [PTR_W-1:0]  ptr_t;
    typedef logic [CNT_W-1:0]  cnt_t;

    typedef struct packed {
        logic  we;
        ptr_t  addr;
        data_t data;
    } wr_req_t;

    function automatic ptr_t next_ptr(input ptr_t ptr);
        return (ptr == ptr_t'(DEPTH - 1)) ? '0 : ptr + ptr_t'(1);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; after a grant the other requester gets preference.
module rr_arb2 (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_en,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt_c
);

    logic r_prio;
    logic w_pick1;

    // Requester 1 wins when it is alone or holds preference.
    assign w_pick1 = i_req[1] & (~i_req[0] | r_prio);
    assign o_gnt_c = {i_en & w_pick1, i_en & i_req[0] & ~w_pick1};

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_prio <= 1'b0;
        end else if (|o_gnt_c) begin
            r_prio <= o_gnt_c[0];
        end
    end

endmodule

// File: rtl/sram16x32DpAr.sv
// 16x32 RAM: one synchronous write port, asynchronous reads at both the read and write addresses.
module sram16x32DpAr (
    input  logic        clock,
    input  logic        writeEnable,
    input  logic [3:0]  writeAddress,
    input  logic [31:0] writeData,
    input  logic [3:0]  readAddress,
    output logic [31:0] dataReadPort,
    output logic [31:0] dataWritePort
);

    logic [31:0] r_mem [16];

    always_ff @(posedge clock) begin
        if (writeEnable) begin
            r_mem[writeAddress] <= writeData;
        end
    end

    assign dataReadPort  = r_mem[readAddress];
    assign dataWritePort = r_mem[writeAddress];

endmodule

// File: rtl/fifo16_rr_ctrl.sv
// Runs a 16x32 RAM as a FIFO: two round-robin producers share the write port, one consumer reads.
module fifo16_rr_ctrl
    import fifo16_pkg::*;
#(
    parameter int unsigned ALMOST_FULL = 12
) (
    input  logic              i_clock,
    input  logic              i_n_reset,
    input  logic              i_flush,
    input  logic              i_req0,
    input  logic              i_req1,
    input  logic [DATA_W-1:0] i_data0,
    input  logic [DATA_W-1:0] i_data1,
    output logic              o_grant0,
    output logic              o_grant1,
    input  logic              i_pop_req,
    output logic [DATA_W-1:0] o_pop_data,
    output logic              o_pop_valid,
    output logic              o_full,
    output logic              o_empty,
    output logic              o_almost_full,
    output logic [CNT_W-1:0]  o_count,
    output logic              o_pop_error
);

    localparam cnt_t AF_LVL = cnt_t'(ALMOST_FULL);

    ptr_t        r_wr_ptr;
    ptr_t        r_rd_ptr;
    cnt_t        r_count;
    logic        r_pop_error;

    logic        w_full;
    logic        w_empty;
    logic        w_grant_en;
    logic [1:0]  w_gnt;
    logic        w_push;
    logic        w_pop;
    wr_req_t     w_wr;
    data_t       w_unused_wr_port;

    assign w_full     = (r_count == cnt_t'(DEPTH));
    assign w_empty    = (r_count == '0);
    assign w_grant_en = i_n_reset & ~w_full & ~i_flush;
    assign w_push     = |w_gnt;
    assign w_pop      = i_pop_req & ~w_empty & ~i_flush;

    rr_arb2 u_arb (
        .i_clk   (i_clock),
        .i_rst_n (i_n_reset),
        .i_en    (w_grant_en),
        .i_req   ({i_req1, i_req0}),
        .o_gnt_c (w_gnt)
    );

    always_comb begin
        w_wr      = '0;
        w_wr.we   = w_push;
        w_wr.addr = r_wr_ptr;
        w_wr.data = w_gnt[1] ? i_data1 : i_data0;
    end

    sram16x32DpAr u_ram (
        .clock         (i_clock),
        .writeEnable   (w_wr.we),
        .writeAddress  (w_wr.addr),
        .writeData     (w_wr.data),
        .readAddress   (r_rd_ptr),
        .dataReadPort  (o_pop_data),
        .dataWritePort (w_unused_wr_port)
    );

    // Occupancy is tracked by count alone, so full and empty never depend on pointer equality.
    always_ff @(posedge i_clock) begin
        if (!i_n_reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_pop_error <= 1'b0;
        end else if (i_flush) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_pop_error <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= next_ptr(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            r_count <= r_count + cnt_t'(w_push) - cnt_t'(w_pop);
            if (i_pop_req && w_empty) begin
                r_pop_error <= 1'b1;
            end
        end
    end

    assign o_grant0      = w_gnt[0];
    assign o_grant1      = w_gnt[1];
    assign o_pop_valid   = ~w_empty;
    assign o_full        = w_full;
    assign o_empty       = w_empty;
    assign o_almost_full = (r_count >= AF_LVL);
    assign o_count       = r_count;
    assign o_pop_error   = r_pop_error;

endmodule

// File: tb/tb_fifo16_rr_ctrl.sv
// Randomized and directed bench for fifo16_rr_ctrl against a queue-based FIFO model.
module tb_fifo16_rr_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        req0 = 1'b0;
    logic        req1 = 1'b0;
    logic [31:0] d0 = '0;
    logic [31:0] d1 = '0;
    logic        pop_req = 1'b0;
    logic        grant0, grant1, pop_valid, full, empty, almost_full, pop_error;
    logic [31:0] pop_data;
    logic [4:0]  count;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] q[$];
    bit          m_prio = 1'b0;
    bit          m_perr = 1'b0;
    bit          e_g0, e_g1;

    fifo16_rr_ctrl #(.ALMOST_FULL(12)) dut (
        .i_clock       (clk),
        .i_n_reset     (rst_n),
        .i_flush       (flush),
        .i_req0        (req0),
        .i_req1        (req1),
        .i_data0       (d0),
        .i_data1       (d1),
        .o_grant0      (grant0),
        .o_grant1      (grant1),
        .i_pop_req     (pop_req),
        .o_pop_data    (pop_data),
        .o_pop_valid   (pop_valid),
        .o_full        (full),
        .o_empty       (empty),
        .o_almost_full (almost_full),
        .o_count       (count),
        .o_pop_error   (pop_error)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected outputs from the queue model for the current inputs.
    task automatic model_check();
        int sz = q.size();
        e_g0 = 1'b0;
        e_g1 = 1'b0;
        if (rst_n && !flush && sz < 16) begin
            if (req0 && req1) begin
                e_g1 = m_prio;
                e_g0 = !m_prio;
            end else begin
                e_g0 = req0;
                e_g1 = req1;
            end
        end
        chk("m_grant0", grant0, e_g0);
        chk("m_grant1", grant1, e_g1);
        chk("m_count", count, sz);
        chk("m_empty", empty, sz == 0);
        chk("m_full", full, sz == 16);
        chk("m_almost_full", almost_full, sz >= 12);
        chk("m_pop_valid", pop_valid, sz != 0);
        chk("m_pop_error", pop_error, m_perr);
        if (sz != 0) chk("m_pop_data", pop_data, q[0]);
    endtask

    task automatic drive(input bit rn, input bit fl, input bit r0, input bit r1,
                         input logic [31:0] a, input logic [31:0] b, input bit p);
        @(negedge clk);
        rst_n = rn; flush = fl; req0 = r0; req1 = r1; d0 = a; d1 = b; pop_req = p;
        #1;
        model_check();
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst_n) begin
            q.delete();
            m_prio = 1'b0;
            m_perr = 1'b0;
        end else if (flush) begin
            q.delete();
            m_perr = 1'b0;
        end else begin
            if (pop_req && q.size() == 0) m_perr = 1'b1;
            if (pop_req && q.size() != 0) void'(q.pop_front());
            if (e_g0) q.push_back(d0);
            if (e_g1) q.push_back(d1);
            if (e_g0 || e_g1) m_prio = e_g0;
        end
    endtask

    task automatic idle();
        drive(1, 0, 0, 0, '0, '0, 0);
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, '0, '0, 0); step();
        drive(0, 0, 0, 0, '0, '0, 0); step();
    endtask

    initial begin
        do_reset();

        // Reset state.
        idle();
        chk("rst_count", count, 5'd0);
        chk("rst_empty", empty, 1'b1);
        chk("rst_pop_valid", pop_valid, 1'b0);
        chk("rst_full", full, 1'b0);
        chk("rst_af", almost_full, 1'b0);
        chk("rst_perr", pop_error, 1'b0);
        chk("rst_grant0", grant0, 1'b0);
        step();

        // Fill with producer 0.
        for (int i = 0; i < 16; i++) begin
            drive(1, 0, 1, 0, 32'hA000_0000 + 32'(i), '0, 0);
            chk("fill_grant0", grant0, 1'b1);
            chk("fill_af", almost_full, i >= 12);
            step();
        end
        drive(1, 0, 1, 0, 32'hA000_0010, '0, 0);
        chk("fill17_grant0", grant0, 1'b0);
        chk("fill17_full", full, 1'b1);
        chk("fill17_count", count, 5'd16);
        step();

        // Full plus pop plus request: pop wins, slot granted next cycle.
        drive(1, 0, 0, 1, '0, 32'hB000_0000, 1);
        chk("fullpop_grant1", grant1, 1'b0);
        chk("fullpop_head", pop_data, 32'hA000_0000);
        step();
        drive(1, 0, 0, 1, '0, 32'hB000_0000, 0);
        chk("fullpop_count15", count, 5'd15);
        chk("fullpop_grant1_next", grant1, 1'b1);
        step();
        idle();
        chk("fullpop_count16", count, 5'd16);
        step();
        for (int k = 0; k < 16; k++) begin
            drive(1, 0, 0, 0, '0, '0, 1);
            chk("drain_order", pop_data, (k < 15) ? 32'hA000_0001 + 32'(k) : 32'hB000_0000);
            step();
        end
        idle();
        chk("drain_empty", empty, 1'b1);
        step();

        // Pop on empty sets the sticky error; no fall-through.
        drive(1, 0, 0, 0, '0, '0, 1);
        step();
        idle();
        chk("perr_set", pop_error, 1'b1);
        chk("perr_count", count, 5'd0);
        step();
        drive(1, 0, 1, 0, 32'h1234_5678, '0, 1);
        chk("nofall_grant0", grant0, 1'b1);
        step();
        idle();
        chk("nofall_valid", pop_valid, 1'b1);
        chk("nofall_data", pop_data, 32'h1234_5678);
        step();

        // Alternating grants under sustained push/pop.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(1, 0, 1, 1, 32'hA000_0000 + 32'(i), 32'hB000_0000 + 32'(i), 1);
            chk("alt_grant0", grant0, (i % 2) == 0);
            chk("alt_grant1", grant1, (i % 2) == 1);
            chk("alt_count", count, (i > 0) ? 5'd1 : 5'd0);
            if (i > 0)
                chk("alt_data", pop_data,
                    (((i - 1) % 2) == 0 ? 32'hA000_0000 : 32'hB000_0000) + 32'(i - 1));
            step();
        end

        // Drain across the 15 -> 0 address wrap.
        do_reset();
        for (int i = 0; i < 12; i++) begin
            drive(1, 0, 1, 0, 32'h5000_0000 + 32'(i), '0, 1);
            step();
        end
        drive(1, 0, 0, 0, '0, '0, 1);
        step();
        for (int k = 0; k < 10; k++) begin
            drive(1, 0, 0, 1, '0, 32'hC000_0000 + 32'(k), 0);
            step();
        end
        for (int k = 0; k < 10; k++) begin
            drive(1, 0, 0, 0, '0, '0, 1);
            chk("wrap_order", pop_data, 32'hC000_0000 + 32'(k));
            step();
        end
        idle();
        chk("wrap_empty", empty, 1'b1);
        step();

        // Flush with pending request; preference survives the flush.
        do_reset();
        drive(1, 0, 0, 0, '0, '0, 1);
        step();
        for (int k = 0; k < 7; k++) begin
            drive(1, 0, 1, 0, 32'hD000_0000 + 32'(k), '0, 0);
            step();
        end
        drive(1, 1, 1, 0, 32'hD000_0007, '0, 0);
        chk("flush_grant0", grant0, 1'b0);
        chk("flush_count7", count, 5'd7);
        step();
        drive(1, 0, 1, 1, 32'hD000_0008, 32'hE000_0000, 0);
        chk("flush_count0", count, 5'd0);
        chk("flush_empty", empty, 1'b1);
        chk("flush_perr", pop_error, 1'b0);
        chk("flush_prio_kept", grant1, 1'b1);
        step();

        // Mid-stream reset.
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, 1, 0, 32'hF000_0000 + 32'(k), '0, 0);
            step();
        end
        drive(0, 0, 1, 1, 32'h1, 32'h2, 1);
        chk("mrst_grant0", grant0, 1'b0);
        chk("mrst_grant1", grant1, 1'b0);
        step();
        idle();
        chk("mrst_count", count, 5'd0);
        chk("mrst_empty", empty, 1'b1);
        chk("mrst_valid", pop_valid, 1'b0);
        chk("mrst_full", full, 1'b0);
        chk("mrst_af", almost_full, 1'b0);
        chk("mrst_perr", pop_error, 1'b0);
        step();

        // Randomized traffic with phases biased toward filling and draining.
        for (int i = 0; i < 4000; i++) begin
            bit rn, fl, r0, r1, p;
            int pop_pct;
            pop_pct = (((i / 300) % 2) == 1) ? 20 : 80;
            rn = ($urandom_range(0, 299) != 0);
            fl = ($urandom_range(0, 79) == 0);
            r0 = ($urandom_range(0, 99) < 60);
            r1 = ($urandom_range(0, 99) < 60);
            p  = ($urandom_range(0, 99) < pop_pct);
            drive(rn, fl, r0, r1, $urandom, $urandom, p);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fifo16_rr_ctrl.md
# fifo16_rr_ctrl

Controller that operates the 16x32 dual-port asynchronous-read RAM (sram16x32DpAr) as a 16-entry FIFO shared by two producers and drained by one consumer. The single RAM write port is granted round-robin between producers, and the read port serves the consumer. It sits between the CPU store path and DMA engine (producers) and a peripheral sink (consumer) in the virtual prototype.

## Interface
- ALMOST_FULL, default 12: count at or above which almostFull asserts (range 1..16).
- clock  in  1  single system clock, all state on rising edge.
- nReset  in  1  synchronous, active-low reset.
- flush  in  1  synchronous clear of FIFO contents.
- req0 / req1  in  1  producer 0/1 push request.
- data0 / data1  in  32  producer 0/1 push data.
- grant0 / grant1  out  1  combinational; push from that producer accepted at this edge.
- popReq  in  1  consumer pop request.
- popData  out  32  head entry, combinational from RAM read port.
- popValid  out  1  head entry valid (= !empty).
- full / empty / almostFull  out  1  status.
- count  out  5  occupancy 0..16.
- popError  out  1  sticky; popReq while empty.

## Operation
- State: wrPtr[3:0], rdPtr[3:0], count[4:0], prio (0 = producer 0 preferred), popError.
- Pointers wrap 15 -> 0; full = (count == 16), empty = (count == 0); pointer equality is never used for full/empty.
- Grant: at most one grant per cycle, only when !full && !flush && nReset.
  - Both requesting: grant the producer selected by prio.
  - One requesting: grant it.
  - After any grant, prio = other producer.
  - No grant leaves prio unchanged.
- Granted push: RAM writeEnable = 1, writeAddress = wrPtr, writeData = granted producer's data; wrPtr++ at edge.
- Pop: when popReq && !empty && !flush, rdPtr++ at edge. RAM readAddress = rdPtr. popData is meaningful only while popValid.
- count next = count + push - pop. Simultaneous push and pop leaves count unchanged.
- Full plus popReq plus requests: pop taken, no grant that cycle; the freed slot becomes grantable next cycle.
- Empty plus push plus popReq: no pop (no fall-through); popError sets; pushed word is visible next cycle.
- popError sets on popReq && empty && !flush; cleared only by reset or flush.
- flush: wrPtr, rdPtr, count, popError to 0; no grant; no pop; prio unchanged. Takes effect at the edge even with requests pending. RAM contents are not cleared.
- Reset (nReset=0 at edge): wrPtr=rdPtr=count=0, prio=0, popError=0. Takes priority over flush and all requests. A transfer in progress is simply discarded.

## Timing
- Reset values:
  - grant0 = grant1 = 0.
  - popValid = 0, empty = 1, full = 0, almostFull = 0, count = 0, popError = 0.
  - popData: undefined.
- Grants are combinational from req and registered state (no req-to-grant register). A producer must hold req/data until it sees grant high at an edge.
- Push-to-popValid latency: 1 cycle. The word written at edge N is on popData after edge N with popValid = 1.
- Pop-to-next-head latency: 0 cycles after the edge. popData updates combinationally from the new rdPtr.
- Sustained throughput: 1 push and 1 pop per cycle.

## Structure
- Package fifo16_pkg:
  - DEPTH = 16, PTR_W = 4, CNT_W = 5, DATA_W = 32.
  - Function nextPtr(ptr) implementing the wrap.
- Sub-module rr_arb2: 2-request round-robin arbiter with prio register, update enable and one-hot grant output.
- One instance of sram16x32DpAr; its dataWritePort is left unused.

## Test plan
- Reset, then req0 with data0=0xA0000000..0xA000000F over 16 cycles -> 16 grants, full=1, count=16, almostFull from count 12. A 17th req0 -> grant0=0.
- req0 and req1 held every cycle from reset, with popReq held -> grants alternate 0,1,0,1; popData order A,B,A,B; count stable at 1 after the first cycle.
- Full FIFO, req1 and popReq in the same cycle -> pop taken, grant1=0, count=15. Next cycle grant1=1, count back to 16.
- Empty FIFO: popReq alone -> popError=1 and count stays 0. Then push 0x12345678 with popReq -> no pop; next cycle popValid=1, popData=0x12345678.
- 10 entries with rdPtr=12, wrPtr=6 (wrapped) -> drain returns entries in order across address 15 -> 0; empty=1 after the 10th pop.
- flush with count=7 and req0 high -> grant0=0; next cycle count=0, empty=1, popError=0, prio unchanged. Mid-stream nReset=0 -> all outputs at reset values on the next cycle.
